// File: rtl/dut_tb_param_pkg.sv
// CSI-2 TX frame scheduler shared types and constants.
// Default payload width, FS/FE data types, scheduler state enum.
package dut_tb_param_pkg;

  localparam int P_CIN_DATA_WIDTH = 32;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HS_ENTER,
    S_FS,
    S_GAP,
    S_LHDR,
    S_LPLD,
    S_FE,
    S_HS_EXIT
  } csi_sched_state_t;

endpackage

// File: rtl/csi_sched_cnt.sv
// Loadable 16-bit down-counter with zero flag.
// Ports: clk, rst_n, load/load_val, dec -> zero.
module csi_sched_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/csi_frame_sched.sv
// CSI-2 TX frame scheduler: HS entry, FS, line packets, FE, HS exit.
// Ports: cfg_*, busy, fifo_*, hs_req/ack, hdr_*, pld_* (see list).
module csi_frame_sched #(
  parameter int          P_CIN_DATA_WIDTH = dut_tb_param_pkg::P_CIN_DATA_WIDTH,
  parameter int          P_LINE_GAP       = 4,
  parameter logic [15:0] P_FRAME_NUM_MAX  = 16'hFFFF
) (
  input  logic                        csi_clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic [1:0]                  cfg_vc,
  input  logic [5:0]                  cfg_dt,
  input  logic [15:0]                 cfg_lines,
  input  logic [15:0]                 cfg_wc,
  output logic                        cfg_err,
  output logic                        busy,
  input  logic [P_CIN_DATA_WIDTH-1:0] fifo_data,
  input  logic                        fifo_valid,
  output logic                        fifo_rd,
  output logic                        hs_req,
  input  logic                        hs_ack,
  output logic                        hdr_valid,
  input  logic                        hdr_ready,
  output logic [7:0]                  hdr_di,
  output logic [15:0]                 hdr_wc,
  output logic                        pld_valid,
  input  logic                        pld_ready,
  output logic [P_CIN_DATA_WIDTH-1:0] pld_data,
  output logic                        pld_last
);

  import dut_tb_param_pkg::*;

  localparam int          BPW     = P_CIN_DATA_WIDTH / 8;
  localparam int          LG      = $clog2(BPW);
  localparam logic [15:0] WC_MASK = 16'(BPW - 1);
  localparam logic [15:0] GAP_LD  = 16'(P_LINE_GAP - 1);

  csi_sched_state_t state, state_nx;

  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [15:0] wtgt_q;
  logic [15:0] frame_num;

  logic wc_ok, accept;
  logic gap_ld, gap_dec, gap_zero;
  logic line_dec, line_zero;
  logic word_ld, word_dec, word_zero;
  logic xfer;

  assign wc_ok  = (cfg_wc != '0) && ((cfg_wc & WC_MASK) == '0);
  assign accept = (state == S_IDLE) && cfg_start && wc_ok;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge csi_clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      vc_q      <= '0;
      dt_q      <= '0;
      wc_q      <= '0;
      wtgt_q    <= '0;
      frame_num <= 16'd1;
      cfg_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && cfg_start) begin
        if (wc_ok) begin
          vc_q    <= cfg_vc;
          dt_q    <= cfg_dt;
          wc_q    <= cfg_wc;
          wtgt_q  <= cfg_wc >> LG;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (state == S_FE && hdr_ready) begin
        frame_num <= (frame_num == P_FRAME_NUM_MAX) ?
                     16'd1 : frame_num + 16'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    gap_ld    = 1'b0;
    gap_dec   = 1'b0;
    line_dec  = 1'b0;
    word_ld   = 1'b0;
    word_dec  = 1'b0;
    xfer      = 1'b0;
    hs_req    = 1'b0;
    hdr_valid = 1'b0;
    hdr_di    = '0;
    hdr_wc    = '0;
    pld_valid = 1'b0;
    pld_data  = '0;
    pld_last  = 1'b0;
    fifo_rd   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_HS_ENTER;
      end
      S_HS_ENTER: begin
        hs_req = 1'b1;
        if (hs_ack) state_nx = S_FS;
      end
      S_FS: begin
        hs_req    = 1'b1;
        hdr_valid = 1'b1;
        hdr_di    = {vc_q, DT_FS};
        hdr_wc    = frame_num;
        if (hdr_ready) begin
          gap_ld   = 1'b1;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        hs_req = 1'b1;
        if (gap_zero) begin
          state_nx = line_zero ? S_FE : S_LHDR;
        end else begin
          gap_dec = 1'b1;
        end
      end
      S_LHDR: begin
        hs_req    = 1'b1;
        hdr_valid = 1'b1;
        hdr_di    = {vc_q, dt_q};
        hdr_wc    = wc_q;
        if (hdr_ready) begin
          word_ld  = 1'b1;
          state_nx = S_LPLD;
        end
      end
      S_LPLD: begin
        hs_req    = 1'b1;
        xfer      = fifo_valid && pld_ready;
        pld_valid = fifo_valid;
        pld_data  = fifo_valid ? fifo_data : '0;
        pld_last  = fifo_valid && word_zero;
        fifo_rd   = xfer;
        if (xfer) begin
          if (word_zero) begin
            line_dec = 1'b1;
            gap_ld   = 1'b1;
            state_nx = S_GAP;
          end else begin
            word_dec = 1'b1;
          end
        end
      end
      S_FE: begin
        hs_req    = 1'b1;
        hdr_valid = 1'b1;
        hdr_di    = {vc_q, DT_FE};
        hdr_wc    = frame_num;
        if (hdr_ready) state_nx = S_HS_EXIT;
      end
      S_HS_EXIT: begin
        if (!hs_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // gap: held for P_LINE_GAP cycles, load is one less than the length
  csi_sched_cnt u_gap (
    .clk      (csi_clk),
    .rst_n    (rst),
    .load     (gap_ld),
    .load_val (GAP_LD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // lines remaining in the frame
  csi_sched_cnt u_line (
    .clk      (csi_clk),
    .rst_n    (rst),
    .load     (accept),
    .load_val (cfg_lines),
    .dec      (line_dec),
    .zero     (line_zero)
  );

  // words remaining in the line; zero marks the last word
  csi_sched_cnt u_word (
    .clk      (csi_clk),
    .rst_n    (rst),
    .load     (word_ld),
    .load_val (wtgt_q - 16'd1),
    .dec      (word_dec),
    .zero     (word_zero)
  );

endmodule

// File: tb/tb_csi_frame_sched.sv
// Directed bench for csi_frame_sched with FIFO, builder and D-PHY models.
// Frame numbering wrap is exercised with P_FRAME_NUM_MAX=3.
module tb_csi_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [1:0]  cfg_vc;
  logic [5:0]  cfg_dt;
  logic [15:0] cfg_lines;
  logic [15:0] cfg_wc;
  logic        cfg_err;
  logic        busy;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_rd;
  logic        hs_req;
  logic        hs_ack;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] pld_data;
  logic        pld_last;

  csi_frame_sched #(
    .P_CIN_DATA_WIDTH (32),
    .P_LINE_GAP       (4),
    .P_FRAME_NUM_MAX  (16'd3)
  ) dut (
    .csi_clk    (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_vc     (cfg_vc),
    .cfg_dt     (cfg_dt),
    .cfg_lines  (cfg_lines),
    .cfg_wc     (cfg_wc),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_rd    (fifo_rd),
    .hs_req     (hs_req),
    .hs_ack     (hs_ack),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_di     (hdr_di),
    .hdr_wc     (hdr_wc),
    .pld_valid  (pld_valid),
    .pld_ready  (pld_ready),
    .pld_data   (pld_data),
    .pld_last   (pld_last)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int rdn  = 0;
  int hvn  = 0;

  logic ack_en = 1'b1;
  logic pr_tog = 1'b0;
  logic fv_gap = 1'b0;
  logic req_d  = 1'b0;

  logic [31:0] fq[$];
  logic [23:0] hlog[$];
  int          hcyc[$];
  logic [32:0] plog[$];

  logic [31:0] w[4];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] hget(input int i);
    return (i < hlog.size()) ? hlog[i] : 24'hFFFFFF;
  endfunction

  function automatic logic [32:0] pget(input int i);
    return (i < plog.size()) ? plog[i] : {33{1'b1}};
  endfunction

  task automatic tick();
    hs_ack     = ack_en & req_d;
    hdr_ready  = 1'b1;
    pld_ready  = pr_tog ? cyc[0] : 1'b1;
    fifo_valid = (fq.size() > 0) && (!fv_gap || (cyc % 3 != 2));
    fifo_data  = (fq.size() > 0) ? fq[0] : 32'h0;
    #1;
    if (hdr_valid) hvn++;
    if (hdr_valid && hdr_ready) begin
      hlog.push_back({hdr_di, hdr_wc});
      hcyc.push_back(cyc);
    end
    if (pld_valid && pld_ready) plog.push_back({pld_last, pld_data});
    if (fifo_rd) begin
      rdn++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    req_d = hs_req;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_logs();
    hlog.delete();
    hcyc.delete();
    plog.delete();
    rdn = 0;
    hvn = 0;
  endtask

  task automatic start(input logic [1:0] vc, input logic [5:0] dt,
                       input logic [15:0] lines, input logic [15:0] wc);
    cfg_vc    = vc;
    cfg_dt    = dt;
    cfg_lines = lines;
    cfg_wc    = wc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    w[0] = 32'hA0A1A2A3;
    w[1] = 32'hB0B1B2B3;
    w[2] = 32'hC0C1C2C3;
    w[3] = 32'hD0D1D2D3;
    rst = 1'b0;
    cfg_start = 1'b0;
    cfg_vc = '0;
    cfg_dt = '0;
    cfg_lines = '0;
    cfg_wc = '0;
    fifo_data = '0;
    fifo_valid = 1'b0;
    hs_ack = 1'b0;
    hdr_ready = 1'b0;
    pld_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {56'd0, busy, hs_req, hdr_valid, pld_valid,
        fifo_rd, pld_last, cfg_err, 1'b0}, 64'd0);
    rst = 1'b1;
    tick();

    // frame 1: vc=1 dt=2A lines=2 wc=8, clean handshakes
    clr_logs();
    for (int i = 0; i < 4; i++) fq.push_back(w[i]);
    start(2'd1, 6'h2A, 16'd2, 16'd8);
    chk("f1_busy", {63'd0, busy}, 64'd1);
    run_idle("f1_done", 300);
    chk("f1_nhdr", hlog.size(), 4);
    chk("f1_fs", hget(0), {8'h40, 16'd1});
    chk("f1_lh0", hget(1), {8'h6A, 16'd8});
    chk("f1_lh1", hget(2), {8'h6A, 16'd8});
    chk("f1_fe", hget(3), {8'h41, 16'd1});
    chk("f1_gap", hcyc[1] - hcyc[0], 5);
    chk("f1_npld", plog.size(), 4);
    chk("f1_p0", pget(0), {1'b0, w[0]});
    chk("f1_p1", pget(1), {1'b1, w[1]});
    chk("f1_p2", pget(2), {1'b0, w[2]});
    chk("f1_p3", pget(3), {1'b1, w[3]});
    chk("f1_rd", rdn, 4);

    // frame 2: same, with pld_ready toggling and FIFO gaps
    clr_logs();
    pr_tog = 1'b1;
    fv_gap = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(w[i]);
    start(2'd1, 6'h2A, 16'd2, 16'd8);
    run_idle("f2_done", 500);
    pr_tog = 1'b0;
    fv_gap = 1'b0;
    chk("f2_fs", hget(0), {8'h40, 16'd2});
    chk("f2_fe", hget(3), {8'h41, 16'd2});
    chk("f2_npld", plog.size(), 4);
    chk("f2_p0", pget(0), {1'b0, w[0]});
    chk("f2_p1", pget(1), {1'b1, w[1]});
    chk("f2_p2", pget(2), {1'b0, w[2]});
    chk("f2_p3", pget(3), {1'b1, w[3]});
    chk("f2_rd", rdn, 4);

    // invalid word count
    clr_logs();
    start(2'd0, 6'h2A, 16'd1, 16'd6);
    chk("bad_wc", {61'd0, cfg_err, busy, hs_req}, 64'b100);
    tick();
    chk("bad_wc_hold", {62'd0, cfg_err, busy}, 64'b10);

    // empty frame, valid start clears error, hs_ack delayed 20 cycles
    ack_en = 1'b0;
    start(2'd2, 6'h2A, 16'd0, 16'd8);
    chk("err_clr", {62'd0, cfg_err, busy}, 64'b01);
    repeat (20) tick();
    chk("ack_wait", {62'd0, hs_req, busy}, 64'b11);
    chk("ack_nohdr", hvn, 0);
    ack_en = 1'b1;
    run_idle("f3_done", 200);
    chk("f3_nhdr", hlog.size(), 2);
    chk("f3_fs", hget(0), {8'h80, 16'd3});
    chk("f3_fe", hget(1), {8'h81, 16'd3});
    chk("f3_rd", rdn, 0);

    // fourth frame: frame number wraps to 1
    clr_logs();
    start(2'd0, 6'h2A, 16'd0, 16'd4);
    run_idle("f4_done", 200);
    chk("f4_fs", hget(0), {8'h00, 16'd1});
    chk("f4_fe", hget(1), {8'h01, 16'd1});

    // reset in the middle of a line after one word
    clr_logs();
    fq.push_back(w[2]);
    fq.push_back(w[3]);
    start(2'd3, 6'h2A, 16'd1, 16'd8);
    for (int i = 0; i < 100 && plog.size() < 1; i++) tick();
    chk("rs_fs", hget(0), {8'hC0, 16'd2});
    chk("rs_one", plog.size(), 1);
    rst = 1'b0;
    #1;
    chk("rs_outs", {32'd0, busy, hs_req, hdr_valid, pld_valid,
        fifo_rd, pld_last, cfg_err, 1'b0, hdr_di, hdr_wc}, 64'd0);
    tick();
    tick();
    chk("rs_nord", rdn, 1);
    rst = 1'b1;
    fq.delete();
    clr_logs();
    start(2'd0, 6'h2A, 16'd0, 16'd8);
    run_idle("rs_done", 200);
    chk("rs_fs1", hget(0), {8'h00, 16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
